// File: rtl/s2_cfg_sequencer.sv
// rtl/s2_cfg_sequencer.sv - load/commit/settle configuration sequencer for an array of S2 logic cells
// Optional feature macro: CFG_PARITY_EN (9-bit config words with odd parity, sticky err output)
module s2_cfg_sequencer #(
  parameter int NUM_CELLS  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
`ifdef CFG_PARITY_EN
  input  logic [8:0]             in_data,
`else
  input  logic [7:0]             in_data,
`endif
  output logic                   in_ready,
  output logic [8*NUM_CELLS-1:0] cfg_out,
  output logic                   cell_clr,
  output logic                   busy,
`ifdef CFG_PARITY_EN
  output logic                   cfg_done,
  output logic                   err
`else
  output logic                   cfg_done
`endif
);

  localparam int CW    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int CFG_W = 8 * NUM_CELLS;
  localparam logic [CW-1:0] LAST_IDX    = CW'(NUM_CELLS - 1);
  localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       settle_cnt, settle_nxt;
  logic [CFG_W-1:0] shadow, shadow_nxt, shadow_wr;
  logic [CFG_W-1:0] cfg_nxt;
  logic             accept;
  logic             word_ok;
`ifdef CFG_PARITY_EN
  logic             err_nxt;
`endif

  // in_ready is a pure decode of state so a word can be taken on the first LOAD cycle
  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;

`ifdef CFG_PARITY_EN
  // Odd parity: all nine bits must XOR to one
  assign word_ok = ^in_data;
`else
  assign word_ok = 1'b1;
`endif

  // Next-state, counters, shadow write and atomic commit
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    settle_nxt = settle_cnt;
    shadow_nxt = shadow;
    cfg_nxt    = cfg_out;
`ifdef CFG_PARITY_EN
    err_nxt    = err;
`endif
    shadow_wr  = shadow;
    shadow_wr[{cnt, 3'b000} +: 8] = in_data[7:0];

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
`ifdef CFG_PARITY_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt  = IDLE;
          shadow_nxt = '0;
        end else if (accept) begin
          if (!word_ok) begin
            state_nxt  = IDLE;
            shadow_nxt = '0;
`ifdef CFG_PARITY_EN
            err_nxt    = 1'b1;
`endif
          end else if (cnt == LAST_IDX) begin
            // Last word goes straight into cfg_out along with the rest of the shadow
            shadow_nxt = shadow_wr;
            cfg_nxt    = shadow_wr;
            settle_nxt = SETTLE_INIT;
            state_nxt  = SETTLE;
          end else begin
            shadow_nxt = shadow_wr;
            cnt_nxt    = cnt + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          settle_nxt = settle_cnt - 4'd1;
        end
      end
      RUN: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
`ifdef CFG_PARITY_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and shadow register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_cnt <= 4'd0;
      shadow     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      settle_cnt <= settle_nxt;
      shadow     <= shadow_nxt;
    end
  end

  // Registered outputs derived from the next state so they change on the transition edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cfg_out  <= '0;
      cell_clr <= 1'b1;
      busy     <= 1'b0;
      cfg_done <= 1'b0;
`ifdef CFG_PARITY_EN
      err      <= 1'b0;
`endif
    end else begin
      cfg_out  <= cfg_nxt;
      cell_clr <= (state_nxt != RUN);
      busy     <= (state_nxt == LOAD) || (state_nxt == SETTLE);
      cfg_done <= (state_nxt == RUN);
`ifdef CFG_PARITY_EN
      err      <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_s2_cfg_sequencer.sv
// tb/tb_s2_cfg_sequencer.sv - directed self-checking bench for s2_cfg_sequencer
module tb_s2_cfg_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start, abort, in_valid;
  logic        start1, in_valid1;
`ifdef CFG_PARITY_EN
  logic [8:0]  in_data, in_data1;
  logic        err, err1;
`else
  logic [7:0]  in_data, in_data1;
`endif
  logic        in_ready, cell_clr, busy, cfg_done;
  logic [31:0] cfg_out;
  logic        in_ready1, cell_clr1, busy1, cfg_done1;
  logic [7:0]  cfg_out1;

  int checks = 0;
  int errors = 0;
  int accepts;
  logic [31:0] exp_q[$];
  logic [7:0]  wv[4];

  always #5 clk = ~clk;

  s2_cfg_sequencer #(.NUM_CELLS(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_out(cfg_out), .cell_clr(cell_clr), .busy(busy),
`ifdef CFG_PARITY_EN
    .cfg_done(cfg_done), .err(err)
`else
    .cfg_done(cfg_done)
`endif
  );

  s2_cfg_sequencer #(.NUM_CELLS(1), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .abort(1'b0),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .cfg_out(cfg_out1), .cell_clr(cell_clr1), .busy(busy1),
`ifdef CFG_PARITY_EN
    .cfg_done(cfg_done1), .err(err1)
`else
    .cfg_done(cfg_done1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [7:0] w);
    in_valid = 1'b1;
`ifdef CFG_PARITY_EN
    in_data = {~^w, w};
`else
    in_data = w;
`endif
  endtask

  task automatic put_word1(input logic [7:0] w);
    in_valid1 = 1'b1;
`ifdef CFG_PARITY_EN
    in_data1 = {~^w, w};
`else
    in_data1 = w;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    step();
    step();
    clr = 1'b0;

    // Reset release with no start: everything idle and held in clear
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_hold", {cell_clr, cfg_done, in_ready, busy, cfg_out}, {4'b1000, 32'h0});
    end

    // Full back-to-back load
    exp_q.push_back(32'h44332211);
    start = 1'b1; step(); start = 1'b0;
    chk("load_entry", {in_ready, busy, cell_clr, cfg_done}, 4'b1110);
    wv = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      put_word(wv[i]);
      step();
    end
    in_valid = 1'b0;
    chk("commit_full", cfg_out, exp_q.pop_front());
    chk("settle_e1", {in_ready, busy, cell_clr, cfg_done}, 4'b0110);
    step();
    chk("settle_e2", {in_ready, busy, cell_clr, cfg_done}, 4'b0110);
    step();
    chk("run_e3", {in_ready, busy, cell_clr, cfg_done}, 4'b0001);

    // Reprogram then abort (abort beats a same-cycle accept)
    start = 1'b1; step(); start = 1'b0;
    chk("reload_clr", {in_ready, busy, cell_clr, cfg_done}, 4'b1110);
    chk("reload_keep", cfg_out, 32'h44332211);
    put_word(8'hAA); step();
    put_word(8'hBB); step();
    put_word(8'hCC); abort = 1'b1; step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_state", {in_ready, busy, cell_clr, cfg_done}, 4'b0010);
    chk("abort_cfg", cfg_out, 32'h44332211);

    // Load with in_valid toggling, start pulsed during SETTLE
    exp_q.push_back(32'h88776655);
    wv = '{8'h55, 8'h66, 8'h77, 8'h88};
    start = 1'b1; step(); start = 1'b0;
    accepts = 0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) put_word(wv[i / 2]);
      else begin
        in_valid = 1'b0;
        in_data = '1;
      end
      if (in_valid && in_ready) accepts++;
      step();
    end
    in_valid = 1'b0;
    chk("toggle_commit", cfg_out, exp_q.pop_front());
    start = 1'b1; step(); start = 1'b0;
    chk("settle_start_ignored", {in_ready, busy, cell_clr, cfg_done}, 4'b0110);
    step();
    chk("toggle_run", {in_ready, busy, cell_clr, cfg_done}, 4'b0001);
    chk("toggle_accepts", accepts, 4);
    put_word(8'h99);
    step(); step(); step();
    in_valid = 1'b0;
    chk("run_valid_ignored", {in_ready, cfg_done, cfg_out}, {2'b01, 32'h88776655});

    // Asynchronous clr between the 2nd and 3rd word
    start = 1'b1; step(); start = 1'b0;
    put_word(8'h01); step();
    put_word(8'h02); step();
    in_valid = 1'b0;
    #2 clr = 1'b1;
    #1 chk("async_clr", {in_ready, busy, cell_clr, cfg_done, cfg_out}, {4'b0010, 32'h0});
    step();
    clr = 1'b0;
    step();
    exp_q.push_back(32'hDEADBEEF);
    wv = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_word(wv[i]);
      step();
    end
    in_valid = 1'b0;
    chk("post_clr_commit", cfg_out, exp_q.pop_front());
    step(); step();
    chk("post_clr_run", {in_ready, busy, cell_clr, cfg_done}, 4'b0001);

    // Single-cell array with minimum settle time
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("n1_entry", {in_ready1, busy1, cell_clr1, cfg_done1}, 4'b1110);
    put_word1(8'h5A); step();
    in_valid1 = 1'b0;
    chk("n1_commit", cfg_out1, 8'h5A);
    chk("n1_settle", {in_ready1, busy1, cell_clr1, cfg_done1}, 4'b0110);
    step();
    chk("n1_run", {in_ready1, busy1, cell_clr1, cfg_done1}, 4'b0001);

`ifdef CFG_PARITY_EN
    // Bad parity on the 3rd word aborts the load and flags err until the next start
    chk("err_init", err, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    put_word(8'h12); step();
    put_word(8'h34); step();
    in_valid = 1'b1; in_data = 9'h0FF; step();
    in_valid = 1'b0;
    chk("par_err", err, 1'b1);
    chk("par_state", {in_ready, busy, cell_clr, cfg_done}, 4'b0010);
    chk("par_cfg", cfg_out, 32'hDEADBEEF);
    start = 1'b1; step(); start = 1'b0;
    chk("err_clear", {err, in_ready}, 2'b01);
    abort = 1'b1; step(); abort = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
